// File: rtl/ec_op_arbiter.sv
// ec_op_arbiter: round-robin arbiter that shares one point add/double engine
// between two requesters, with a per-operation timeout and a sticky error flag.
module ec_op_arbiter #(
  parameter int unsigned W           = 256,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic             i_req1_valid,
  input  logic             i_req0_op,
  input  logic             i_req1_op,
  input  logic [3*W-1:0]   i_req0_pa,
  input  logic [3*W-1:0]   i_req1_pa,
  input  logic [3*W-1:0]   i_req0_pb,
  input  logic [3*W-1:0]   i_req1_pb,
  output logic             o_req0_ready,
  output logic             o_req1_ready,
  output logic             o_rsp0_valid,
  output logic             o_rsp1_valid,
  output logic [3*W-1:0]   o_rsp_pt,
  output logic             o_rsp_err,
  output logic             o_eng_start,
  output logic             o_eng_op,
  output logic [3*W-1:0]   o_eng_pa,
  output logic [3*W-1:0]   o_eng_pb,
  output logic             o_eng_rst_n,
  input  logic             i_eng_done,
  input  logic [3*W-1:0]   i_eng_pt,
  output logic             o_busy,
  output logic             o_timeout_err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic        last_served;
  logic        owner;
  logic        eng_run;
  logic [15:0] tmo_cnt;
  logic        grant0;
  logic        grant1;

  // Grant: sole valid wins, a tie goes to whoever was not served last.
  always_comb begin
    grant0       = i_req0_valid & (~i_req1_valid | last_served);
    grant1       = i_req1_valid & (~i_req0_valid | ~last_served);
    o_req0_ready = i_rst_n & (state == IDLE) & grant0;
    o_req1_ready = i_rst_n & (state == IDLE) & grant1;
  end

  // Engine clear is low in RESP and follows reset directly so it is low while reset is held.
  assign o_eng_rst_n = i_rst_n & eng_run;

  // Arbiter FSM with registered command/response outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      last_served   <= 1'b1;
      owner         <= 1'b0;
      eng_run       <= 1'b1;
      tmo_cnt       <= '0;
      o_eng_start   <= 1'b0;
      o_eng_op      <= 1'b0;
      o_eng_pa      <= '0;
      o_eng_pb      <= '0;
      o_rsp0_valid  <= 1'b0;
      o_rsp1_valid  <= 1'b0;
      o_rsp_pt      <= '0;
      o_rsp_err     <= 1'b0;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (o_req0_ready || o_req1_ready) begin
            owner       <= o_req1_ready;
            last_served <= o_req1_ready;
            o_eng_op    <= o_req1_ready ? i_req1_op : i_req0_op;
            o_eng_pa    <= o_req1_ready ? i_req1_pa : i_req0_pa;
            o_eng_pb    <= o_req1_ready ? i_req1_pb : i_req0_pb;
            tmo_cnt     <= '0;
            o_eng_start <= 1'b1;
            o_busy      <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (i_eng_done || tmo_cnt == TMO_LAST) begin
            // Done is tested first so a completion on the expiry cycle still returns a valid result.
            o_rsp_pt      <= i_eng_done ? i_eng_pt : '0;
            o_rsp_err     <= ~i_eng_done;
            o_timeout_err <= o_timeout_err | ~i_eng_done;
            o_eng_start   <= 1'b0;
            eng_run       <= 1'b0;
            o_rsp0_valid  <= ~owner;
            o_rsp1_valid  <= owner;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: begin
          o_rsp0_valid <= 1'b0;
          o_rsp1_valid <= 1'b0;
          eng_run      <= 1'b1;
          o_busy       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
